// File: rtl/pipe_mem_arbiter_if.sv
// pipe_mem_arbiter_if: memory-side bus between the arbiter and the unified memory.
//   master (arbiter): drives o_mem_req/wren/addr/wdata/bmask, samples i_mem_ack/i_mem_rdata.
//   slave  (memory) : the reverse.
// Signal names are given from the arbiter's point of view.
interface pipe_mem_arbiter_if;
    logic        o_mem_req;
    logic        o_mem_wren;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_bmask;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;

    modport master (
        output o_mem_req, o_mem_wren, o_mem_addr, o_mem_wdata, o_mem_bmask,
        input  i_mem_ack, i_mem_rdata
    );
    modport slave (
        input  o_mem_req, o_mem_wren, o_mem_addr, o_mem_wdata, o_mem_bmask,
        output i_mem_ack, i_mem_rdata
    );
endinterface

// File: rtl/pipe_mem_arbiter.sv
// pipe_mem_arbiter: shares one single-ported memory between instruction fetch (IF)
// and the load/store unit (LS). LS has priority; a fairness counter forces an IF
// grant after MAX_LS_BURST consecutive LS grants while IF waits. Each access runs
// IDLE -> ISSUE -> RESP; a missing ack is aborted after TIMEOUT_CYC ISSUE cycles.
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_if_req/addr/kill           fetch request, address, pipeline flush
//   o_if_valid/rdata, o_stall_if fetch response strobe/data, fetch stall
//   i_ls_req/wren/addr/wdata/bmask  load/store request
//   o_ls_valid/rdata, o_stall_ls LS response strobe/data, LS stall
//   o_err                        strobes with a response whose access timed out
//   mem                          memory bus (pipe_mem_arbiter_if.master)
module pipe_mem_arbiter #(
    parameter int unsigned MAX_LS_BURST = 4,
    parameter int unsigned TIMEOUT_CYC  = 64
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    input  logic        i_if_kill,
    output logic        o_if_valid,
    output logic [31:0] o_if_rdata,
    output logic        o_stall_if,
    input  logic        i_ls_req,
    input  logic        i_ls_wren,
    input  logic [31:0] i_ls_addr,
    input  logic [31:0] i_ls_wdata,
    input  logic [3:0]  i_ls_bmask,
    output logic        o_ls_valid,
    output logic [31:0] o_ls_rdata,
    output logic        o_stall_ls,
    output logic        o_err,
    pipe_mem_arbiter_if.master mem
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_e;

    localparam logic [3:0] FAIR_MAX = 4'(MAX_LS_BURST);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

    state_e      state_q, state_d;
    logic        owner_if_q, owner_if_d;
    logic [3:0]  fair_q, fair_d;
    logic        kill_q, kill_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_wren_q, mem_wren_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_bmask_q, mem_bmask_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic        ls_valid_q, ls_valid_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;
    logic        err_q, err_d;

    logic        grant_if, done, timed_out;
    logic [31:0] rd;

    always_comb begin
        state_d     = state_q;
        owner_if_d  = owner_if_q;
        fair_d      = fair_q;
        kill_d      = kill_q;
        tmo_d       = tmo_q;
        mem_req_d   = mem_req_q;
        mem_wren_d  = mem_wren_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_bmask_d = mem_bmask_q;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;
        if_valid_d  = 1'b0;
        ls_valid_d  = 1'b0;
        err_d       = 1'b0;
        grant_if    = 1'b0;
        done        = 1'b0;
        timed_out   = 1'b0;
        rd          = '0;

        case (state_q)
            S_IDLE: begin
                if (!i_if_req) fair_d = '0;
                if (i_if_req || i_ls_req) begin
                    grant_if   = i_if_req && (!i_ls_req || fair_q == FAIR_MAX);
                    owner_if_d = grant_if;
                    mem_req_d  = 1'b1;
                    state_d    = S_ISSUE;
                    if (grant_if) begin
                        mem_wren_d  = 1'b0;
                        mem_addr_d  = i_if_addr;
                        mem_wdata_d = '0;
                        mem_bmask_d = 4'hF;
                        fair_d      = '0;
                    end else begin
                        mem_wren_d  = i_ls_wren;
                        mem_addr_d  = i_ls_addr;
                        mem_wdata_d = i_ls_wdata;
                        mem_bmask_d = i_ls_wren ? i_ls_bmask : 4'hF;
                        // LS overtook a waiting fetch: count toward the forced IF grant.
                        if (i_if_req && fair_q != FAIR_MAX) fair_d = fair_q + 4'd1;
                    end
                end
            end
            S_ISSUE: begin
                if (owner_if_q && i_if_kill) kill_d = 1'b1;
                if (mem.i_mem_ack) begin
                    done = 1'b1;
                    rd   = mem_wren_q ? 32'h0 : mem.i_mem_rdata;
                end else if (tmo_q == TMO_LAST) begin
                    done      = 1'b1;
                    timed_out = 1'b1;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
                if (done) begin
                    mem_req_d = 1'b0;
                    state_d   = S_RESP;
                    // Strobes are registered so they appear during RESP; a kill
                    // arriving in the final ISSUE cycle must still suppress them.
                    if (owner_if_q) begin
                        if (!(kill_q || i_if_kill)) begin
                            if_valid_d = 1'b1;
                            if_rdata_d = rd;
                            err_d      = timed_out;
                        end
                    end else begin
                        ls_valid_d = 1'b1;
                        ls_rdata_d = rd;
                        err_d      = timed_out;
                    end
                end
            end
            S_RESP: begin
                kill_d  = 1'b0;
                tmo_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            owner_if_q  <= 1'b0;
            fair_q      <= '0;
            kill_q      <= 1'b0;
            tmo_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_wren_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_bmask_q <= '0;
            if_valid_q  <= 1'b0;
            if_rdata_q  <= '0;
            ls_valid_q  <= 1'b0;
            ls_rdata_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_if_q  <= owner_if_d;
            fair_q      <= fair_d;
            kill_q      <= kill_d;
            tmo_q       <= tmo_d;
            mem_req_q   <= mem_req_d;
            mem_wren_q  <= mem_wren_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_bmask_q <= mem_bmask_d;
            if_valid_q  <= if_valid_d;
            if_rdata_q  <= if_rdata_d;
            ls_valid_q  <= ls_valid_d;
            ls_rdata_q  <= ls_rdata_d;
            err_q       <= err_d;
        end
    end

    assign mem.o_mem_req   = mem_req_q;
    assign mem.o_mem_wren  = mem_wren_q;
    assign mem.o_mem_addr  = mem_addr_q;
    assign mem.o_mem_wdata = mem_wdata_q;
    assign mem.o_mem_bmask = mem_bmask_q;

    assign o_if_valid = if_valid_q;
    assign o_if_rdata = if_rdata_q;
    assign o_ls_valid = ls_valid_q;
    assign o_ls_rdata = ls_rdata_q;
    assign o_err      = err_q;
    assign o_stall_if = i_if_req & ~if_valid_q;
    assign o_stall_ls = i_ls_req & ~ls_valid_q;
endmodule

// File: tb/tb_pipe_mem_arbiter.sv
module tb_pipe_mem_arbiter;
    localparam int MAXB = 4;
    localparam int TMO  = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_kill;
    logic [31:0] if_addr;
    logic        if_valid, stall_if;
    logic [31:0] if_rdata;
    logic        ls_req, ls_wren;
    logic [31:0] ls_addr, ls_wdata;
    logic [3:0]  ls_bmask;
    logic        ls_valid, stall_ls, err;
    logic [31:0] ls_rdata;

    always #5 clk = ~clk;

    pipe_mem_arbiter_if mif();

    pipe_mem_arbiter #(.MAX_LS_BURST(MAXB), .TIMEOUT_CYC(TMO)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_if_req(if_req), .i_if_addr(if_addr), .i_if_kill(if_kill),
        .o_if_valid(if_valid), .o_if_rdata(if_rdata), .o_stall_if(stall_if),
        .i_ls_req(ls_req), .i_ls_wren(ls_wren), .i_ls_addr(ls_addr),
        .i_ls_wdata(ls_wdata), .i_ls_bmask(ls_bmask),
        .o_ls_valid(ls_valid), .o_ls_rdata(ls_rdata), .o_stall_ls(stall_ls),
        .o_err(err), .mem(mif)
    );

    typedef struct { logic wren; logic [31:0] addr; logic [31:0] wdata; logic [3:0] bmask; } mreq_t;
    typedef struct { logic [31:0] rdata; logic err; } resp_t;

    mreq_t       mq_if[$], mq_ls[$];
    logic [31:0] rq_if[$];
    resp_t       rq_ls[$];
    int          grant_log[$];
    int          total = 0, bad = 0;
    int          force_dly = -1;
    bit          no_ack = 1'b0;
    bit          go = 1'b0;
    int          cur_dly = 0;

    // Memory contents: a fixed function of the address (one test-plan word pinned).
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        if (a == 32'h10) return 32'h0051_3023;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // ---------------- memory responder ----------------
    bit mbusy = 1'b0;
    int mcnt  = 0;
    initial begin
        mif.i_mem_ack   = 1'b0;
        mif.i_mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst || mif.o_mem_req !== 1'b1) begin
                mbusy = 1'b0;
                mif.i_mem_ack   = 1'b0;
                mif.i_mem_rdata = '0;
            end else begin
                if (!mbusy) begin
                    mbusy = 1'b1;
                    mcnt  = 0;
                    cur_dly = no_ack ? 1000 : (force_dly >= 0 ? force_dly : int'($urandom_range(0, 3)));
                end else mcnt++;
                mif.i_mem_ack   = (mcnt == cur_dly);
                mif.i_mem_rdata = (mcnt == cur_dly) ? mem_f(mif.o_mem_addr) : $urandom;
            end
        end
    end

    // ---------------- memory-side monitor: grant order + request contents ----------------
    bit    pv_if = 1'b0, pv_ls = 1'b0, prev_req = 1'b0, aborted = 1'b0;
    int    streak = 0, len = 0;
    mreq_t cur_exp;
    initial begin
        wait (go);
        forever begin
            @(negedge clk);
            if (rst) begin
                streak = 0;
                if (prev_req) aborted = 1'b1;
            end
            if (mif.o_mem_req === 1'b1 && !prev_req) begin
                bit exp_if;
                exp_if = pv_if && (!pv_ls || streak == MAXB);
                grant_log.push_back(mif.o_mem_addr < 32'h4000 ? 1 : 0);
                chk("grant_owner", {31'b0, mif.o_mem_addr < 32'h4000}, {31'b0, exp_if});
                if (!exp_if && pv_if) streak = (streak < MAXB) ? streak + 1 : MAXB;
                else streak = 0;
                if ((exp_if ? mq_if.size() : mq_ls.size()) == 0) begin
                    total++; bad++;
                    $display("FAIL grant_unexpected: addr %h with no pending request", mif.o_mem_addr);
                end else begin
                    cur_exp = exp_if ? mq_if.pop_front() : mq_ls.pop_front();
                    chk("mem_addr", mif.o_mem_addr, cur_exp.addr);
                    chk("mem_wren", {31'b0, mif.o_mem_wren}, {31'b0, cur_exp.wren});
                    chk("mem_bmask", {28'b0, mif.o_mem_bmask}, {28'b0, cur_exp.bmask});
                    if (cur_exp.wren) chk("mem_wdata", mif.o_mem_wdata, cur_exp.wdata);
                end
                len = 1;
                aborted = 1'b0;
            end else if (mif.o_mem_req === 1'b1) begin
                len++;
                chk("mem_hold_addr", mif.o_mem_addr, cur_exp.addr);
            end else if (prev_req && !aborted) begin
                chk("issue_len", len, (cur_dly >= TMO) ? TMO : cur_dly + 1);
            end
            prev_req = (mif.o_mem_req === 1'b1);
            pv_if = if_req;
            pv_ls = ls_req;
        end
    end

    // ---------------- response scoreboard ----------------
    initial begin
        logic [31:0] e;
        resp_t r;
        wait (go);
        forever begin
            @(negedge clk);
            if (if_valid === 1'b1) begin
                if (rq_if.size() == 0) begin
                    total++; bad++;
                    $display("FAIL if_spurious: valid with rdata %h, none expected", if_rdata);
                end else begin
                    e = rq_if.pop_front();
                    chk("if_rdata", if_rdata, e);
                    chk("if_err", {31'b0, err}, 32'h0);
                end
                chk("stall_if_on_valid", {31'b0, stall_if}, 32'h0);
            end else chk("stall_if", {31'b0, stall_if}, {31'b0, if_req});
            if (ls_valid === 1'b1) begin
                if (rq_ls.size() == 0) begin
                    total++; bad++;
                    $display("FAIL ls_spurious: valid with rdata %h, none expected", ls_rdata);
                end else begin
                    r = rq_ls.pop_front();
                    chk("ls_rdata", ls_rdata, r.rdata);
                    chk("ls_err", {31'b0, err}, {31'b0, r.err});
                end
                chk("stall_ls_on_valid", {31'b0, stall_ls}, 32'h0);
            end else chk("stall_ls", {31'b0, stall_ls}, {31'b0, ls_req});
            if (err === 1'b1 && if_valid !== 1'b1 && ls_valid !== 1'b1) begin
                total++; bad++;
                $display("FAIL err_alone: o_err=1 without a valid strobe");
            end
        end
    end

    // ---------------- requester drivers ----------------
    task automatic if_access(input logic [31:0] a, input int kill_at);
        mreq_t m;
        int n = 0, iss = 0;
        bit done = 1'b0;
        m.wren = 1'b0; m.addr = a; m.wdata = '0; m.bmask = 4'hF;
        mq_if.push_back(m);
        if (kill_at < 0) rq_if.push_back(mem_f(a));
        if_req = 1'b1; if_addr = a;
        while (!done) begin
            tick(); n++;
            if (kill_at >= 0 && mif.o_mem_req === 1'b1 && mif.o_mem_addr == a) begin
                if (iss == kill_at) begin
                    if_kill = 1'b1; tick(); if_kill = 1'b0; done = 1'b1;
                end
                iss++;
            end else if (kill_at < 0 && if_valid === 1'b1) done = 1'b1;
            if (!done && n > 300) begin
                total++; bad++;
                $display("FAIL if_wait_expired: addr %h got no response", a);
                done = 1'b1;
            end
        end
        if_req = 1'b0;
    endtask

    task automatic ls_access(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        mreq_t m;
        resp_t r;
        int n = 0;
        m.wren = w; m.addr = a; m.wdata = d; m.bmask = w ? be : 4'hF;
        mq_ls.push_back(m);
        r.rdata = (w || no_ack) ? 32'h0 : mem_f(a);
        r.err   = no_ack;
        rq_ls.push_back(r);
        ls_req = 1'b1; ls_wren = w; ls_addr = a; ls_wdata = d; ls_bmask = be;
        do begin
            tick(); n++;
        end while (ls_valid !== 1'b1 && n <= 300);
        if (n > 300) begin
            total++; bad++;
            $display("FAIL ls_wait_expired: addr %h got no response", a);
        end
        ls_req = 1'b0;
    endtask

    task automatic check_order(input string name, input int exp[$]);
        chk({name, "_len"}, grant_log.size(), exp.size());
        for (int i = 0; i < exp.size() && i < grant_log.size(); i++)
            chk(name, grant_log[i], exp[i]);
    endtask

    // ---------------- main stimulus ----------------
    initial begin
        int ord[$];
        mreq_t m;
        int n;
        rst = 1'b1; if_req = 1'b0; if_kill = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_wren = 1'b0; ls_addr = '0; ls_wdata = '0; ls_bmask = '0;
        tick(); tick();
        chk("rst_mem_req", {31'b0, mif.o_mem_req}, 32'h0);
        chk("rst_mem_addr", mif.o_mem_addr, 32'h0);
        chk("rst_mem_bmask", {28'b0, mif.o_mem_bmask}, 32'h0);
        chk("rst_if_valid", {31'b0, if_valid}, 32'h0);
        chk("rst_ls_valid", {31'b0, ls_valid}, 32'h0);
        chk("rst_err", {31'b0, err}, 32'h0);
        rst = 1'b0;
        go = 1'b1;
        tick();

        // single fetch, ack in second ISSUE cycle
        force_dly = 1;
        if_access(32'h10, -1);
        tick(); tick();

        // simultaneous IF + LS store: LS first, then IF
        force_dly = 0;
        grant_log.delete();
        fork
            if_access(32'h44, -1);
            ls_access(1'b1, 32'h7000, 32'hDEAD_BEEF, 4'b0011);
        join
        ord = '{0, 1};
        check_order("order_simul", ord);
        tick(); tick();

        // IF held while LS issues 6 back-to-back loads
        force_dly = -1;
        grant_log.delete();
        fork
            if_access(32'h100, -1);
            for (int i = 0; i < 6; i++) ls_access(1'b0, 32'h7000 + 32'(i * 4), 32'h0, 4'h0);
        join
        ord = '{0, 0, 0, 0, 1, 0, 0};
        check_order("order_fair", ord);
        tick(); tick();

        // kill in second ISSUE cycle, ack one cycle later; next fetch normal
        force_dly = 2;
        if_access(32'h80, 1);
        force_dly = -1;
        tick(); tick();
        if_access(32'h84, -1);
        tick(); tick();

        // lost acknowledge -> timeout
        no_ack = 1'b1;
        ls_access(1'b0, 32'h7100, 32'h0, 4'h0);
        no_ack = 1'b0;
        tick(); tick();
        ls_access(1'b0, 32'h7104, 32'h0, 4'h0);
        tick(); tick();

        // reset in the middle of an LS store
        no_ack = 1'b1;
        m.wren = 1'b1; m.addr = 32'h7200; m.wdata = 32'h1234_5678; m.bmask = 4'hC;
        mq_ls.push_back(m);
        ls_req = 1'b1; ls_wren = 1'b1; ls_addr = 32'h7200; ls_wdata = 32'h1234_5678; ls_bmask = 4'hC;
        n = 0;
        do begin tick(); n++; end while (mif.o_mem_req !== 1'b1 && n < 20);
        chk("rst_test_granted", {31'b0, mif.o_mem_req}, 32'h1);
        tick();
        rst = 1'b1; ls_req = 1'b0;
        tick();
        chk("midrst_mem_req", {31'b0, mif.o_mem_req}, 32'h0);
        chk("midrst_mem_wren", {31'b0, mif.o_mem_wren}, 32'h0);
        chk("midrst_mem_addr", mif.o_mem_addr, 32'h0);
        chk("midrst_mem_wdata", mif.o_mem_wdata, 32'h0);
        chk("midrst_mem_bmask", {28'b0, mif.o_mem_bmask}, 32'h0);
        chk("midrst_ls_valid", {31'b0, ls_valid}, 32'h0);
        chk("midrst_ls_rdata", ls_rdata, 32'h0);
        chk("midrst_if_rdata", if_rdata, 32'h0);
        chk("midrst_err", {31'b0, err}, 32'h0);
        rst = 1'b0; no_ack = 1'b0;
        m.wren = 1'b0; m.addr = 32'h20; m.wdata = '0; m.bmask = 4'hF;
        mq_if.push_back(m);
        rq_if.push_back(mem_f(32'h20));
        if_req = 1'b1; if_addr = 32'h20;
        tick();
        chk("postrst_first_grant", {31'b0, mif.o_mem_req}, 32'h1);
        n = 0;
        while (if_valid !== 1'b1 && n < 50) begin tick(); n++; end
        chk("postrst_if_done", {31'b0, if_valid}, 32'h1);
        if_req = 1'b0;
        tick(); tick();

        // randomized traffic
        fork
            for (int i = 0; i < 40; i++) begin
                repeat ($urandom_range(0, 3)) tick();
                if_access(32'($urandom_range(0, 1023)) << 2, ($urandom_range(0, 4) == 0) ? 0 : -1);
            end
            for (int j = 0; j < 40; j++) begin
                repeat ($urandom_range(0, 2)) tick();
                ls_access(1'($urandom_range(0, 1)), 32'h7000 + (32'($urandom_range(0, 255)) << 2),
                          $urandom, 4'($urandom_range(1, 15)));
            end
        join
        repeat (5) tick();
        chk("drain_mq", mq_if.size() + mq_ls.size(), 32'h0);
        chk("drain_rq", rq_if.size() + rq_ls.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/pipe_mem_arbiter.md
Name: pipe_mem_arbiter

Overview:
- Shares a single-ported unified instruction/data memory between two requesters of the 5-stage pipeline: instruction fetch (IF) and the load/store unit (LS, MEM stage).
- Sequences every access through a 3-state FSM and holds the memory-side handshake until the memory acknowledges.
- Returns registered responses and drives per-requester stall lines to the hazard logic.
- Gives LS priority, with a fairness counter so that fetch cannot starve, and a timeout so that a lost acknowledge cannot hang the core.

Parameters:
- MAX_LS_BURST, 4: consecutive LS grants allowed while IF is waiting before IF is forced a grant (range 1..15).
- TIMEOUT_CYC, 64: cycles in ISSUE without i_mem_ack before the access is aborted (range 2..255).

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  synchronous reset, active-high
- i_if_req  in  1  fetch request; held until o_if_valid or i_if_kill
- i_if_addr  in  32  fetch address; stable while i_if_req is high
- i_if_kill  in  1  pipeline flush; discards an outstanding fetch response
- o_if_valid  out  1  one-cycle fetch response strobe
- o_if_rdata  out  32  fetch data; valid when o_if_valid=1
- o_stall_if  out  1  i_if_req & ~o_if_valid
- i_ls_req  in  1  LS request; held until o_ls_valid
- i_ls_wren  in  1  1 = store, 0 = load
- i_ls_addr  in  32  LS address
- i_ls_wdata  in  32  store data
- i_ls_bmask  in  4  store byte enables
- o_ls_valid  out  1  one-cycle LS response strobe
- o_ls_rdata  out  32  load data; 0 for stores
- o_stall_ls  out  1  i_ls_req & ~o_ls_valid
- o_err  out  1  pulses together with a valid strobe when that access timed out
- o_mem_req  out  1  memory request
- o_mem_wren  out  1  memory write enable
- o_mem_addr  out  32  memory address
- o_mem_wdata  out  32  memory write data
- o_mem_bmask  out  4  memory byte enables; 4'hF for reads
- i_mem_ack  in  1  memory completion; sampled only while o_mem_req=1
- i_mem_rdata  in  32  read data; valid in the i_mem_ack cycle

Behaviour:

Reset (i_rst high at a clock edge, from any state):
- state=IDLE; fairness counter=0; kill flag=0; timeout counter=0.
- All registered outputs are 0: o_mem_req, o_mem_wren, o_mem_addr, o_mem_wdata, o_mem_bmask, o_if_valid, o_ls_valid, o_if_rdata, o_ls_rdata, o_err.
- A reset mid-access drops o_mem_req in the next cycle. No valid strobe is ever produced for the aborted access.

IDLE:
- No request: remain in IDLE.
- Only i_ls_req: grant LS.
- Only i_if_req: grant IF.
- Both requests: grant LS, unless fairness counter == MAX_LS_BURST, in which case grant IF.
- On a grant: latch owner, addr, wren, wdata and bmask into the memory-side registers (reads force bmask=4'hF, wren=0); set o_mem_req=1; go to ISSUE.

ISSUE:
- o_mem_* registers are held stable.
- Each cycle without i_mem_ack increments the timeout counter.
- On i_mem_ack: capture i_mem_rdata (0 if the access is a store); drop o_mem_req; go to RESP.
- If the timeout counter reaches TIMEOUT_CYC without ack: drop o_mem_req; rdata=0; set the error flag; go to RESP.

RESP (exactly one cycle):
- Pulse the owner's valid strobe with its rdata, and o_err if the error flag is set.
- Exception: if owner=IF and the kill flag is set, no strobe and no o_err.
- Clear the kill flag, error flag and timeout counter; go to IDLE.

Timing:
- Minimum access latency: grant edge -> o_mem_req, ack in the first ISSUE cycle, valid strobe one cycle later.
- Best-case throughput is one access per 3 cycles.
- The requester may drop or change its request at the edge that ends RESP. IDLE re-samples requests in the following cycle, so a completed request is never re-granted.

Fairness counter:
- On an LS grant with i_if_req=1: increment, saturating at MAX_LS_BURST.
- On an IF grant, or on any IDLE cycle with i_if_req=0: clear to 0.

Kill:
- i_if_kill is sampled every cycle.
- Set the kill flag if owner=IF and state is ISSUE or RESP.
- An IF request that is not yet granted is unaffected; the requester withdraws or changes it itself.
- The memory access itself always completes; it is never cancelled.

Other rules:
- LS stores update memory even if they time out; o_err is informational only.
- No combinational path from i_mem_ack to o_mem_req. o_stall_* are combinational from the request and valid signals.

Test Plan:
- Single fetch, addr=0x0000_0010, memory acks after 2 cycles with 0x0051_3023 -> o_mem_req high for 2 cycles with addr 0x10, bmask 4'hF, wren=0; o_if_valid pulses for 1 cycle with rdata 0x0051_3023; o_stall_if is high until that pulse.
- Simultaneous IF and LS store (addr 0x0000_7000, wdata 0xDEAD_BEEF, bmask 4'b0011), immediate ack -> LS is served first with o_mem_wren=1, bmask 4'b0011, o_ls_rdata=0; IF is granted on the next IDLE cycle.
- IF held continuously while LS issues 6 back-to-back loads, MAX_LS_BURST=4 -> memory grant order is LS, LS, LS, LS, IF, LS, LS.
- Fetch granted, i_if_kill pulsed in the second ISSUE cycle, ack 1 cycle later -> memory access completes; o_if_valid stays 0; the next IF request is served normally.
- Memory never acks, TIMEOUT_CYC=64, LS load -> o_mem_req drops after exactly 64 ISSUE cycles; o_ls_valid and o_err pulse together with o_ls_rdata=0; the FSM returns to IDLE.
- i_rst asserted during ISSUE of an LS store -> o_mem_req=0 and all outputs 0 the next cycle; no o_ls_valid; an IF request after reset is granted on its first IDLE cycle.
